// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks:
// the controller state encoding and the default operand width.
package serial_arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: difference and borrow-out from x - y - Bin.
// Purely combinational; the serial controller owns every flop.
module full_subtractor (
    input  logic Bin,
    input  logic x,
    input  logic y,
    output logic d,
    output logic Bout
);

    assign d    = x ^ y ^ Bin;
    assign Bout = (~x & y) | (~x & Bin) | (y & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes (x - y) mod 2^N one bit per clock,
// LSB first, reusing a single full_subtractor cell and a borrow flop.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         start,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] d,
    output logic         Bout
);

    localparam int CNT_W = $clog2(N + 1);

    state_t             state_q, state_d;
    logic [N-1:0]       xReg_q, xReg_d;
    logic [N-1:0]       yReg_q, yReg_d;
    logic [N-1:0]       res_q, res_d;
    logic               borrow_q, borrow_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [N-1:0]       dOut_q, dOut_d;
    logic               bOut_q, bOut_d;

    logic               dBit;
    logic               bNext;

    full_subtractor uBit (
        .Bin  (borrow_q),
        .x    (xReg_q[0]),
        .y    (yReg_q[0]),
        .d    (dBit),
        .Bout (bNext)
    );

    always_comb begin
        state_d  = state_q;
        xReg_d   = xReg_q;
        yReg_d   = yReg_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        count_d  = count_q;
        dOut_d   = dOut_q;
        bOut_d   = bOut_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    xReg_d   = x;
                    yReg_d   = y;
                    res_d    = '0;
                    borrow_d = 1'b0;
                    count_d  = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                xReg_d   = {1'b0, xReg_q[N-1:1]};
                yReg_d   = {1'b0, yReg_q[N-1:1]};
                res_d    = {dBit, res_q[N-1:1]};
                borrow_d = bNext;
                count_d  = count_q + 1'b1;
                // The last bit is folded straight into the visible result so it
                // appears in the same cycle that done is raised.
                if (count_q == CNT_W'(N - 1)) begin
                    dOut_d  = {dBit, res_q[N-1:1]};
                    bOut_d  = bNext;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= IDLE;
            xReg_q   <= '0;
            yReg_q   <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            count_q  <= '0;
            dOut_q   <= '0;
            bOut_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            xReg_q   <= xReg_d;
            yReg_q   <= yReg_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            count_q  <= count_d;
            dOut_q   <= dOut_d;
            bOut_q   <= bOut_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign d    = dOut_q;
    assign Bout = bOut_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (N=8): directed corner cases,
// mid-operation disturbance, async reset abort, back-to-back and random runs.
module tb_serial_subtractor;

    logic       Clock;
    logic       Resetn;
    logic       start;
    logic [7:0] x;
    logic [7:0] y;
    logic       busy;
    logic       done;
    logic [7:0] d;
    logic       Bout;

    int         testsRun;
    int         testsFailed;
    logic [7:0] prevD;
    logic       prevB;

    serial_subtractor #(.N(8)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .start  (start),
        .x      (x),
        .y      (y),
        .busy   (busy),
        .done   (done),
        .d      (d),
        .Bout   (Bout)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One full operation; optionally pulses start and scrambles x/y mid-flight.
    task automatic applyStimulus(input logic [7:0] ax, input logic [7:0] ay, input bit midPulse);
        logic [7:0] expD;
        logic       expB;
        expD = ax - ay;
        expB = (ax < ay);
        @(negedge Clock);
        start = 1'b1;
        x = ax;
        y = ay;
        @(negedge Clock);
        start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            checkOutput("busy", 32'(busy), 32'd1);
            checkOutput("doneLow", 32'(done), 32'd0);
            checkOutput("dHold", 32'(d), 32'(prevD));
            checkOutput("boutHold", 32'(Bout), 32'(prevB));
            if (midPulse && i == 3) begin
                start = 1'b1;
                x = 8'($urandom);
                y = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge Clock);
        end
        checkOutput("done", 32'(done), 32'd1);
        checkOutput("busyInDone", 32'(busy), 32'd0);
        checkOutput("d", 32'(d), 32'(expD));
        checkOutput("Bout", 32'(Bout), 32'(expB));
        prevD = expD;
        prevB = expB;
        @(negedge Clock);
        checkOutput("doneOnce", 32'(done), 32'd0);
        checkOutput("busyIdle", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0] xs [3];
        logic [7:0] ys [3];
        int         nDone;
        int         lastCyc;

        testsRun    = 0;
        testsFailed = 0;
        prevD       = 8'd0;
        prevB       = 1'b0;
        Resetn      = 1'b0;
        start       = 1'b0;
        x           = 8'd0;
        y           = 8'd0;

        #1;
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstD", 32'(d), 32'd0);
        checkOutput("rstBout", 32'(Bout), 32'd0);
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;

        applyStimulus(8'd100, 8'd37, 1'b0);
        applyStimulus(8'd37, 8'd100, 1'b0);
        applyStimulus(8'd0, 8'd1, 1'b0);
        applyStimulus(8'd255, 8'd255, 1'b0);
        applyStimulus(8'd100, 8'd37, 1'b1);

        // Abort an operation with reset during its fourth SHIFT cycle.
        @(negedge Clock);
        start = 1'b1;
        x = 8'd150;
        y = 8'd20;
        @(negedge Clock);
        start = 1'b0;
        repeat (3) @(negedge Clock);
        checkOutput("preAbortBusy", 32'(busy), 32'd1);
        Resetn = 1'b0;
        #1;
        checkOutput("abortBusy", 32'(busy), 32'd0);
        checkOutput("abortDone", 32'(done), 32'd0);
        checkOutput("abortD", 32'(d), 32'd0);
        checkOutput("abortBout", 32'(Bout), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            checkOutput("abortNoDone", 32'(done), 32'd0);
        end
        Resetn = 1'b1;
        prevD = 8'd0;
        prevB = 1'b0;
        applyStimulus(8'd200, 8'd55, 1'b0);

        // Start held high: three operations, done pulses N+2 cycles apart.
        xs = '{8'd10, 8'd3, 8'd250};
        ys = '{8'd4, 8'd9, 8'd250};
        nDone = 0;
        lastCyc = 0;
        @(negedge Clock);
        x = xs[0];
        y = ys[0];
        start = 1'b1;
        for (int c = 0; c < 40 && nDone < 3; c++) begin
            @(negedge Clock);
            if (done) begin
                checkOutput("b2bD", 32'(d), 32'(8'(xs[nDone] - ys[nDone])));
                checkOutput("b2bBout", 32'(Bout), 32'(xs[nDone] < ys[nDone]));
                if (nDone > 0) checkOutput("b2bGap", 32'(c - lastCyc), 32'd10);
                lastCyc = c;
                nDone++;
                if (nDone < 3) begin
                    x = xs[nDone];
                    y = ys[nDone];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        checkOutput("b2bCount", 32'(nDone), 32'd3);
        prevD = xs[2] - ys[2];
        prevB = (xs[2] < ys[2]);
        @(negedge Clock);
        checkOutput("b2bIdle", 32'(busy), 32'd0);

        for (int n = 0; n < 1000; n++) begin
            applyStimulus(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
